druaga_spra_buffer: RTL and testbench

- CPU-side writer for the sprite attribute interface consumed by the video sprite generator (SPRA_A/SPRA_D, 128 x 24-bit).
- CPU sees three byte-wide shadow banks.
- On each vertical-blank rising edge, a copy engine transfers all entries into a display buffer. The video side therefore reads a stable, frame-coherent sprite list.
- Sits between the main CPU bus decode and the video block.

---
 rtl/druaga_spra_buffer.sv | 105 ++++++++++
 tb/tb_druaga_spra_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/druaga_spra_buffer.sv
// druaga_spra_buffer: CPU shadow sprite RAM copied into a frame-coherent display buffer on each VB rising edge.
module druaga_spra_buffer #(
  parameter int AW = 7,
  parameter int BANKS_USED = 3
) (
  input  logic          VCLKx8,
  input  logic          RESET,
  input  logic          CPU_CS,
  input  logic          CPU_WE,
  input  logic [AW+1:0] CPU_A,
  input  logic [7:0]    CPU_DI,
  output logic [7:0]    CPU_DO,
  input  logic          VB,
  input  logic [AW-1:0] SPRA_A,
  output logic [23:0]   SPRA_D,
  output logic          BUSY,
  output logic          DONE
);
  localparam int N = 2**AW;
  typedef enum logic [1:0] {IDLE, COPY, FLUSH} state_t;
  logic [7:0] shadow [BANKS_USED][N];
  logic [23:0] disp [N];
  state_t state_q, state_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic [23:0] cp_data_q, cp_data_d, spra_d_q, spra_d_d;
  logic [7:0] cpu_do_q, cpu_do_d;
  logic busy_q, busy_d, done_q, done_d, wr_pend_q, wr_pend_d, vb_q;
  logic [1:0] bank;
  logic [AW-1:0] idx;
  logic bank_ok, cpu_wr, cpu_rd, start, disp_we;
  assign bank = CPU_A[AW+1:AW];
  assign idx = CPU_A[AW-1:0];
  assign bank_ok = int'(bank) < BANKS_USED;
  assign cpu_wr = CPU_CS & CPU_WE & bank_ok;
  assign cpu_rd = CPU_CS & ~CPU_WE;
  assign start = VB & ~vb_q;
  // A reset on the cycle of a pending display write suppresses that write too.
  assign disp_we = wr_pend_q & ~RESET;
  assign CPU_DO = cpu_do_q;
  assign SPRA_D = spra_d_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  always_ff @(posedge VCLKx8) begin
    if (cpu_wr) shadow[bank][idx] <= CPU_DI;
  end
  always_ff @(posedge VCLKx8) begin
    if (disp_we) disp[wr_idx_q] <= cp_data_q;
  end
  always_comb begin
    cpu_do_d = cpu_rd ? (bank_ok ? shadow[bank][idx] : 8'h00) : cpu_do_q;
    spra_d_d = disp[SPRA_A];
    state_d = state_q;
    rd_idx_d = rd_idx_q;
    wr_idx_d = wr_idx_q;
    cp_data_d = cp_data_q;
    busy_d = busy_q;
    done_d = 1'b0;
    wr_pend_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        busy_d = 1'b1;
        rd_idx_d = '0;
        state_d = COPY;
      end
      COPY: begin
        cp_data_d = {shadow[2][rd_idx_q], shadow[1][rd_idx_q], shadow[0][rd_idx_q]};
        wr_pend_d = 1'b1;
        wr_idx_d = rd_idx_q;
        rd_idx_d = rd_idx_q + 1'b1;
        state_d = (rd_idx_q == AW'(N - 1)) ? FLUSH : COPY;
      end
      FLUSH: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge VCLKx8) begin
    if (RESET) begin
      state_q <= IDLE;
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      cp_data_q <= '0;
      spra_d_q <= '0;
      cpu_do_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wr_pend_q <= 1'b0;
      vb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      cp_data_q <= cp_data_d;
      spra_d_q <= spra_d_d;
      cpu_do_q <= cpu_do_d;
      busy_q <= busy_d;
      done_q <= done_d;
      wr_pend_q <= wr_pend_d;
      vb_q <= VB;
    end
  end
endmodule

// File: tb/tb_druaga_spra_buffer.sv
// tb_druaga_spra_buffer: scenario tasks plus a cycle scoreboard for the sprite attribute buffer.
module tb_druaga_spra_buffer;
  localparam int N = 128;
  logic clk = 0, rst = 1, cs = 0, we = 0, vb = 0;
  logic [8:0] a = '0;
  logic [7:0] di = '0;
  logic [6:0] sa = '0;
  logic [7:0] cpu_do;
  logic [23:0] spra_d;
  logic busy, done;
  int total = 0, bad = 0;
  druaga_spra_buffer dut (
    .VCLKx8(clk), .RESET(rst), .CPU_CS(cs), .CPU_WE(we), .CPU_A(a), .CPU_DI(di),
    .CPU_DO(cpu_do), .VB(vb), .SPRA_A(sa), .SPRA_D(spra_d), .BUSY(busy), .DONE(done)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic busy;
    logic done;
    logic [7:0] cdo;
    logic [23:0] sd;
    logic sdk;
  } exp_t;
  exp_t sb[$];
  logic [7:0] m_sh [3][N];
  logic [23:0] m_disp [N];
  bit m_dk [N];
  int m_ph = -1;
  logic m_vbd = 0, m_cv = 0;
  logic [23:0] m_cap = '0;
  logic [6:0] m_cidx = '0;
  logic [7:0] m_cdo = '0;
  // Reference model: evaluated at each rising edge on the inputs that were set up before it.
  always @(posedge clk) begin
    exp_t e;
    e = '0;
    if (rst) begin
      m_ph = -1;
      m_vbd = 0;
      m_cv = 0;
      m_cdo = '0;
      e.sdk = 1'b1;
    end else begin
      e.sd = m_disp[sa];
      e.sdk = m_dk[sa];
      if (cs && !we) m_cdo = (a[8:7] == 2'd3) ? 8'h00 : m_sh[a[8:7]][a[6:0]];
      e.done = (m_ph == 128);
      if (m_cv) begin
        m_disp[m_cidx] = m_cap;
        m_dk[m_cidx] = 1;
        m_cv = 0;
      end
      if (m_ph >= 0 && m_ph < 128) begin
        m_cidx = 7'(m_ph);
        m_cap = {m_sh[2][m_cidx], m_sh[1][m_cidx], m_sh[0][m_cidx]};
        m_cv = 1;
      end
      if (cs && we && a[8:7] != 2'd3) m_sh[a[8:7]][a[6:0]] = di;
      if (m_ph == 128) m_ph = -1;
      else if (m_ph >= 0) m_ph++;
      else if (vb && !m_vbd) m_ph = 0;
      m_vbd = vb;
      e.busy = (m_ph >= 0);
      e.cdo = m_cdo;
    end
    sb.push_back(e);
  end
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (busy !== e.busy) begin bad++; $display("FAIL sb_busy t=%0t got=%0b exp=%0b", $time, busy, e.busy); end
      total++;
      if (done !== e.done) begin bad++; $display("FAIL sb_done t=%0t got=%0b exp=%0b", $time, done, e.done); end
      total++;
      if (cpu_do !== e.cdo) begin bad++; $display("FAIL sb_cpu_do t=%0t got=%h exp=%h", $time, cpu_do, e.cdo); end
      if (e.sdk) begin
        total++;
        if (spra_d !== e.sd) begin bad++; $display("FAIL sb_spra_d t=%0t got=%h exp=%h", $time, spra_d, e.sd); end
      end
    end
  end
  function automatic logic [7:0] pat(int s, int b, int i);
    return 8'(i * 5 + b * 77 + s * 31 + 3);
  endfunction
  function automatic logic [23:0] ent(int s, int i);
    return {pat(s, 2, i), pat(s, 1, i), pat(s, 0, i)};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] b, input logic [6:0] i, input logic [7:0] d);
    cs = 1; we = 1; a = {b, i}; di = d;
    tick();
    cs = 0; we = 0;
  endtask
  task automatic rd(input logic [1:0] b, input logic [6:0] i);
    cs = 1; we = 0; a = {b, i};
    tick();
    cs = 0;
  endtask
  task automatic fill(input int s);
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < N; i++) wr(2'(b), 7'(i), pat(s, b, i));
  endtask
  task automatic run_copy(input bit retrig, input bit sweep, output int bcnt, output int dcnt, output bit order_ok);
    int last_b, first_d;
    bcnt = 0; dcnt = 0; last_b = -1; first_d = -1;
    vb = 1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (busy) begin bcnt++; last_b = k; end
      if (done) begin dcnt++; if (first_d < 0) first_d = k; end
      if (sweep) sa = sa + 1'b1;
      if (!retrig && k == 2) vb = 0;
      if (retrig) vb = (k < 47 || (k >= 50 && k < 55));
    end
    vb = 0;
    order_ok = (first_d == last_b + 1);
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (cpu_do !== 8'h00) begin bad++; $display("FAIL reset_cpu_do got=%h exp=00", cpu_do); end
    total++; if (spra_d !== 24'h0) begin bad++; $display("FAIL reset_spra_d got=%h exp=000000", spra_d); end
    rst = 0;
    tick();
  endtask
  task automatic test_write_readback();
    wr(2'd1, 7'h10, 8'hA5);
    rd(2'd1, 7'h10);
    total++; if (cpu_do !== 8'hA5) begin bad++; $display("FAIL readback got=%h exp=a5", cpu_do); end
    repeat (2) tick();
    total++; if (cpu_do !== 8'hA5) begin bad++; $display("FAIL cpu_do_hold got=%h exp=a5", cpu_do); end
    wr(2'd3, 7'h10, 8'h5A);
    rd(2'd3, 7'h10);
    total++; if (cpu_do !== 8'h00) begin bad++; $display("FAIL bank3_read got=%h exp=00", cpu_do); end
    rd(2'd0, 7'h10);
    total++; if (cpu_do !== pat(1, 0, 16)) begin bad++; $display("FAIL bank0_untouched got=%h exp=%h", cpu_do, pat(1, 0, 16)); end
    rd(2'd2, 7'h7F);
    total++; if (cpu_do !== pat(1, 2, 127)) begin bad++; $display("FAIL bank2_top got=%h exp=%h", cpu_do, pat(1, 2, 127)); end
  endtask
  task automatic test_frame_copy();
    int bc, dc;
    bit ok;
    wr(2'd0, 7'd5, 8'h11);
    wr(2'd1, 7'd5, 8'h22);
    wr(2'd2, 7'd5, 8'h33);
    run_copy(0, 0, bc, dc, ok);
    total++; if (bc != 129) begin bad++; $display("FAIL frame_busy_len got=%0d exp=129", bc); end
    total++; if (dc != 1) begin bad++; $display("FAIL frame_done_cnt got=%0d exp=1", dc); end
    total++; if (!ok) begin bad++; $display("FAIL frame_done_order got=0 exp=1"); end
    sa = 7'd5; tick();
    total++; if (spra_d !== 24'h332211) begin bad++; $display("FAIL frame_idx5 got=%h exp=332211", spra_d); end
    sa = 7'd100; tick();
    total++; if (spra_d !== ent(1, 100)) begin bad++; $display("FAIL frame_idx100 got=%h exp=%h", spra_d, ent(1, 100)); end
  endtask
  task automatic test_collision();
    int bc, dc;
    bit ok;
    vb = 1; tick(); vb = 0;
    repeat (64) tick();
    cs = 1; we = 1; a = {2'd0, 7'd64}; di = 8'hFF;
    tick();
    cs = 0; we = 0;
    repeat (100) tick();
    sa = 7'd64; tick();
    total++; if (spra_d[7:0] !== pat(1, 0, 64)) begin bad++; $display("FAIL collision_old got=%h exp=%h", spra_d[7:0], pat(1, 0, 64)); end
    run_copy(0, 0, bc, dc, ok);
    sa = 7'd64; tick();
    total++; if (spra_d[7:0] !== 8'hFF) begin bad++; $display("FAIL collision_next got=%h exp=ff", spra_d[7:0]); end
  endtask
  task automatic test_retrigger();
    int bc, dc;
    bit ok;
    run_copy(1, 0, bc, dc, ok);
    total++; if (bc != 129) begin bad++; $display("FAIL retrig_busy_len got=%0d exp=129", bc); end
    total++; if (dc != 1) begin bad++; $display("FAIL retrig_done_cnt got=%0d exp=1", dc); end
  endtask
  task automatic test_video_sweep();
    int bc, dc;
    bit ok;
    fill(2);
    sa = '0;
    run_copy(0, 1, bc, dc, ok);
    total++; if (bc != 129) begin bad++; $display("FAIL sweep_busy_len got=%0d exp=129", bc); end
    sa = 7'd64; tick();
    total++; if (spra_d !== ent(2, 64)) begin bad++; $display("FAIL sweep_idx64 got=%h exp=%h", spra_d, ent(2, 64)); end
  endtask
  task automatic test_reset_mid_copy();
    int bc, dc, nb, nd;
    bit ok;
    fill(3);
    vb = 1; tick(); vb = 0;
    repeat (70) tick();
    rst = 1; tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    rst = 0;
    nb = 0; nd = 0;
    repeat (140) begin tick(); nb += busy; nd += done; end
    total++; if (nb != 0 || nd != 0) begin bad++; $display("FAIL rstmid_quiet got=busy%0d/done%0d exp=0/0", nb, nd); end
    for (int i = 0; i < N; i++) begin
      sa = 7'(i); tick();
      total++;
      if (spra_d !== (i <= 68 ? ent(3, i) : ent(2, i))) begin
        bad++; $display("FAIL rstmid_entry%0d got=%h exp=%h", i, spra_d, (i <= 68 ? ent(3, i) : ent(2, i)));
      end
    end
    run_copy(0, 0, bc, dc, ok);
    total++; if (bc != 129 || dc != 1) begin bad++; $display("FAIL rstmid_recopy got=%0d/%0d exp=129/1", bc, dc); end
    for (int i = 60; i < N; i += 11) begin
      sa = 7'(i); tick();
      total++; if (spra_d !== ent(3, i)) begin bad++; $display("FAIL recopy_entry%0d got=%h exp=%h", i, spra_d, ent(3, i)); end
    end
  endtask
  initial begin
    test_reset();
    fill(1);
    test_write_readback();
    test_frame_copy();
    test_collision();
    test_retrigger();
    test_video_sweep();
    test_reset_mid_copy();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
